// File: rtl/matrix_pkg.sv
// matrix_pkg: shared loader state type and default word width for the matrix memory blocks
package matrix_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} loader_state_t;
  localparam int MATRIX_MEM_WIDTH_DEFAULT = 32;
endpackage

// File: rtl/matrix_memory_loader.sv
// matrix_memory_loader: streams words into the A memory then the B memory, then pulses memory_filled
//   in : clk, rst, load_start, abort, in_data, in_valid
//   out: in_ready, wr_en_a/wr_address_a/wr_data_a, wr_en_b/wr_address_b/wr_data_b, memory_filled, busy
module matrix_memory_loader
  import matrix_pkg::*;
#(
  parameter int MATRIX_A_MEM_DEPTH = 16,
  parameter int MATRIX_B_MEM_DEPTH = 8,
  parameter int MATRIX_MEM_WIDTH = MATRIX_MEM_WIDTH_DEFAULT,
  localparam int AW_A = MATRIX_A_MEM_DEPTH > 1 ? $clog2(MATRIX_A_MEM_DEPTH) : 1,
  localparam int AW_B = MATRIX_B_MEM_DEPTH > 1 ? $clog2(MATRIX_B_MEM_DEPTH) : 1,
  localparam int MAX_D = MATRIX_A_MEM_DEPTH > MATRIX_B_MEM_DEPTH ? MATRIX_A_MEM_DEPTH : MATRIX_B_MEM_DEPTH,
  localparam int CW = MAX_D > 1 ? $clog2(MAX_D) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        abort,
  input  logic [MATRIX_MEM_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        wr_en_a,
  output logic [AW_A-1:0]             wr_address_a,
  output logic [MATRIX_MEM_WIDTH-1:0] wr_data_a,
  output logic                        wr_en_b,
  output logic [AW_B-1:0]             wr_address_b,
  output logic [MATRIX_MEM_WIDTH-1:0] wr_data_b,
  output logic                        memory_filled,
  output logic                        busy
);
  loader_state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_wr_en_a, r_wr_en_b, r_filled;
  logic [AW_A-1:0] r_addr_a;
  logic [AW_B-1:0] r_addr_b;
  logic [MATRIX_MEM_WIDTH-1:0] r_data_a, r_data_b;
  logic w_beat, w_beat_a, w_beat_b, w_last_a, w_last_b;
  assign w_beat   = in_valid && in_ready;
  assign w_beat_a = w_beat && r_state == LOAD_A;
  assign w_beat_b = w_beat && r_state == LOAD_B;
  assign w_last_a = r_cnt == CW'(MATRIX_A_MEM_DEPTH - 1);
  assign w_last_b = r_cnt == CW'(MATRIX_B_MEM_DEPTH - 1);
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = load_start ? LOAD_A : IDLE;
      LOAD_A:  w_next = abort ? IDLE : (w_beat && w_last_a) ? LOAD_B : LOAD_A;
      LOAD_B:  w_next = abort ? IDLE : (w_beat && w_last_b) ? DONE : LOAD_B;
      default: w_next = IDLE;
    endcase
  end
  // busy stays up through the memory_filled cycle, which follows the DONE state
  always_comb begin
    in_ready = (r_state == LOAD_A || r_state == LOAD_B) && !abort;
    busy     = r_state != IDLE || r_filled;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_wr_en_a <= 1'b0;
      r_wr_en_b <= 1'b0;
      r_filled  <= 1'b0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_data_a  <= '0;
      r_data_b  <= '0;
    end else begin
      r_wr_en_a <= w_beat_a;
      r_wr_en_b <= w_beat_b;
      r_filled  <= r_state == DONE;
      // IDLE always holds the counter at zero, so every load starts from address 0
      r_cnt     <= (r_state == IDLE || (w_beat_a && w_last_a)) ? '0 : r_cnt + CW'(w_beat);
      if (w_beat_a) begin
        r_addr_a <= r_cnt[AW_A-1:0];
        r_data_a <= in_data;
      end
      if (w_beat_b) begin
        r_addr_b <= r_cnt[AW_B-1:0];
        r_data_b <= in_data;
      end
    end
  end
  assign wr_en_a       = r_wr_en_a;
  assign wr_address_a  = r_addr_a;
  assign wr_data_a     = r_data_a;
  assign wr_en_b       = r_wr_en_b;
  assign wr_address_b  = r_addr_b;
  assign wr_data_b     = r_data_b;
  assign memory_filled = r_filled;
endmodule
